// File: rtl/sobel_result_if.sv
// sobel_result_if
//   Bundles the pixel stream and the Nios II custom-instruction signals of the
//   Sobel result reader.
//
//   Handshake rules, in one place:
//     Pixel stream: a pixel moves on a rising clk edge where pix_valid and
//       pix_ready are both high. pix_ready does not depend on pix_valid.
//       A pixel presented while pix_ready is low is dropped, not held.
//     Instruction: start is a one-cycle request, qualified by clk_en and
//       accepted only while the reader is idle. done is a completion pulse,
//       and result carries data only while done is high (0 otherwise).
//       With clk_en low the reader holds its state, including done.
//
//   master: pixel producer + CPU side (drives pix_valid/pix_data/clk_en/start/n)
//   slave : sobel_result_reader (drives pix_ready/done/result)
interface sobel_result_if #(
   parameter int PIXEL_W = 8
);
   logic               pix_valid;
   logic [PIXEL_W-1:0] pix_data;
   logic               pix_ready;
   logic               clk_en;
   logic               start;
   logic [1:0]         n;
   logic               done;
   logic [31:0]        result;

   modport master (
      output pix_valid, pix_data, clk_en, start, n,
      input  pix_ready, done, result
   );

   modport slave (
      input  pix_valid, pix_data, clk_en, start, n,
      output pix_ready, done, result
   );
endinterface

// File: rtl/sobel_result_reader.sv
// sobel_result_reader
//   Output side of the Sobel custom instruction. Gradient pixels of one image
//   row are written into a two-bank ping-pong buffer; the CPU reads them back
//   as packed 32-bit words (pixel 4k in bits 7:0 ... pixel 4k+3 in 31:24).
//
//   Ports:
//     clk       - rising-edge clock
//     reset     - synchronous, active-high; clears all state
//     bus       - sobel_result_if.slave: pixel stream + instruction handshake
//     state_dbg - current read FSM state (0 IDLE, 1 WAIT_DATA, 2 RESP)
//
//   Opcodes on n: 0 READ, 1 STATUS, 2 CLEAR, 3 behaves as STATUS.
module sobel_result_reader #(
   parameter int PIXEL_W     = 8,
   parameter int LINE_PIXELS = 64,
   parameter int OUT_PIXELS  = LINE_PIXELS - 2,
   parameter int WORDS       = (OUT_PIXELS + 3) / 4
) (
   input  logic          clk,
   input  logic          reset,
   sobel_result_if.slave bus,
   output logic [1:0]    state_dbg
);

   localparam int W_IDX = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;
   localparam int R_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_CLEAR = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      RESP      = 2'd2
   } state_t;

   state_t state, state_next;

   logic [PIXEL_W-1:0] mem [0:1][0:OUT_PIXELS-1];

   logic [1:0]       full, full_next;
   logic             w_bank, r_bank;
   logic [W_IDX-1:0] w_idx;
   logic [R_W-1:0]   r_word;
   logic [1:0]       op_q;
   logic [31:0]      result_q, result_next;
   logic [31:0]      rd_word, status_word;

   logic wr_fire, wr_last, rd_retire, rd_last;
   logic do_clear, load_result, latch_op;
   int   lane_idx;

   assign bus.pix_ready = ~full[w_bank];
   // A CLEAR in the same cycle as a pixel wins; the pixel is discarded.
   assign wr_fire   = bus.pix_valid & bus.pix_ready & ~do_clear;
   assign wr_last   = (w_idx == W_IDX'(OUT_PIXELS - 1));
   assign rd_last   = (r_word == R_W'(WORDS - 1));

   assign status_word = 32'({full, r_bank, w_bank, r_word, w_idx});

   // Gather the four lanes of the current read word; lanes past the end of
   // the row read as zero.
   always_comb begin
      rd_word  = '0;
      lane_idx = 0;
      for (int j = 0; j < 4; j++) begin
         lane_idx = int'(r_word) * 4 + j;
         if (lane_idx < OUT_PIXELS)
            rd_word[j*8 +: 8] = 8'(mem[r_bank][W_IDX'(lane_idx)]);
      end
   end

   // Read FSM next state. The result is captured on entry to RESP so that
   // done and result are both plain registered values while in RESP.
   always_comb begin
      state_next  = state;
      load_result = 1'b0;
      result_next = '0;
      do_clear    = 1'b0;
      rd_retire   = 1'b0;
      latch_op    = 1'b0;
      if (bus.clk_en) begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  latch_op = 1'b1;
                  if (bus.n == OP_READ) begin
                     if (full[r_bank]) begin
                        state_next  = RESP;
                        load_result = 1'b1;
                        result_next = rd_word;
                     end else begin
                        state_next = WAIT_DATA;
                     end
                  end else if (bus.n == OP_CLEAR) begin
                     do_clear    = 1'b1;
                     state_next  = RESP;
                     load_result = 1'b1;
                     result_next = '0;
                  end else begin
                     state_next  = RESP;
                     load_result = 1'b1;
                     result_next = status_word;
                  end
               end
            end
            WAIT_DATA: begin
               if (full[r_bank]) begin
                  state_next  = RESP;
                  load_result = 1'b1;
                  result_next = rd_word;
               end
            end
            RESP: begin
               state_next = IDLE;
               rd_retire  = (op_q == OP_READ);
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Writer only ever fills a non-full bank and the reader only frees a full
   // one, so the two updates always touch different bits.
   always_comb begin
      full_next = full;
      if (wr_fire && wr_last)
         full_next[w_bank] = 1'b1;
      if (rd_retire && rd_last)
         full_next[r_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         result_q <= '0;
         full     <= '0;
         w_bank   <= 1'b0;
         r_bank   <= 1'b0;
         w_idx    <= '0;
         r_word   <= '0;
      end else begin
         state <= state_next;
         if (latch_op)
            op_q <= bus.n;
         if (load_result)
            result_q <= result_next;
         if (do_clear) begin
            full   <= '0;
            w_bank <= 1'b0;
            r_bank <= 1'b0;
            w_idx  <= '0;
            r_word <= '0;
         end else begin
            full <= full_next;
            if (wr_fire) begin
               if (wr_last) begin
                  w_idx  <= '0;
                  w_bank <= ~w_bank;
               end else begin
                  w_idx <= w_idx + 1'b1;
               end
            end
            if (rd_retire) begin
               if (rd_last) begin
                  r_word <= '0;
                  r_bank <= ~r_bank;
               end else begin
                  r_word <= r_word + 1'b1;
               end
            end
         end
      end
   end

   // Pixel storage has no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_fire && !reset)
         mem[w_bank][w_idx] <= bus.pix_data;
   end

   assign bus.done   = (state == RESP);
   assign bus.result = (state == RESP) ? result_q : 32'h0;
   assign state_dbg  = state;

endmodule
